// File: rtl/pwm_deadtime.sv
// Complementary high/low-side drive from one PWM level.
// Adds dead time at each commutation and counts swallowed pulses.
module pwm_deadtime #(
  parameter int DT_SIZE   = 8,
  parameter int DROP_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 pwm_in,
  input  logic [DT_SIZE-1:0]   dead_time,
  output logic                 hs_out,
  output logic                 ls_out,
  output logic                 dt_active,
  output logic [DROP_SIZE-1:0] drop_cnt
);

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_DT  = 2'd1;
  localparam logic [1:0] S_HS  = 2'd2;
  localparam logic [1:0] S_LS  = 2'd3;

  localparam logic [DT_SIZE-1:0]   CNT_ONE  = 1;
  localparam logic [DROP_SIZE-1:0] DROP_ONE = 1;

  logic [1:0]           state_q, state_d;
  logic [DT_SIZE-1:0]   cnt_q, cnt_d;
  logic                 prev_q, prev_d;
  logic [DROP_SIZE-1:0] drop_q, drop_d;
  logic                 hs_q, hs_d;
  logic                 ls_q, ls_d;
  logic                 dta_q, dta_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    drop_d  = drop_q;
    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          state_d = S_DT;
          cnt_d   = dead_time;
          prev_d  = ~pwm_in;
        end
        S_HS: begin
          if (!pwm_in) begin
            state_d = S_DT;
            cnt_d   = dead_time;
            prev_d  = 1'b1;
          end
        end
        S_LS: begin
          if (pwm_in) begin
            state_d = S_DT;
            cnt_d   = dead_time;
            prev_d  = 1'b0;
          end
        end
        S_DT: begin
          // a zero dead time still costs one both-off cycle
          if (cnt_q <= CNT_ONE) begin
            state_d = pwm_in ? S_HS : S_LS;
            cnt_d   = '0;
            if (pwm_in == prev_q && drop_q != '1)
              drop_d = drop_q + DROP_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
    hs_d  = (state_d == S_HS);
    ls_d  = (state_d == S_LS);
    dta_d = (state_d == S_DT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      drop_q  <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      dta_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      drop_q  <= drop_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      dta_q   <= dta_d;
    end
  end

  assign hs_out    = hs_q;
  assign ls_out    = ls_q;
  assign dt_active = dta_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and random checks for pwm_deadtime.
// Inputs change 1ns after posedge; a negedge monitor checks gaps.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pwm_in;
  logic [7:0] dead_time;
  logic       hs_out;
  logic       ls_out;
  logic       dt_active;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  pwm_deadtime #(.DT_SIZE(8), .DROP_SIZE(8)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .dead_time(dead_time), .hs_out(hs_out), .ls_out(ls_out),
    .dt_active(dt_active), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // negedge monitor: no overlap, rise preceded by enough both-low cycles
  int   lowcnt = 0;
  int   req = 1;
  logic hs_p = 0, ls_p = 0, dta_p = 0;
  logic [7:0] dt_p = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("overlap", {31'd0, hs_out & ls_out}, 0);
      if (dt_active && !dta_p)
        req = (dt_p == 0) ? 1 : int'(dt_p);
      if ((hs_out && !hs_p) || (ls_out && !ls_p))
        chk("gap", {31'd0, lowcnt >= req}, 1);
      lowcnt = (hs_out | ls_out) ? 0 : lowcnt + 1;
    end
    dt_p  = dead_time;
    hs_p  = hs_out;
    ls_p  = ls_out;
    dta_p = dt_active;
  end

  initial begin
    rst = 1; en = 0; pwm_in = 0; dead_time = 8'd4;
    step(2);
    chk("rst_hs", hs_out, 0);
    chk("rst_ls", ls_out, 0);
    chk("rst_dta", dt_active, 0);
    chk("rst_drop", drop_cnt, 0);

    // bring-up, dead_time=4
    rst = 0; en = 1; pwm_in = 1; dead_time = 8'd4;
    mon_en = 1;
    step(1);
    chk("up_dta", dt_active, 1);
    step(3);
    chk("up_hs_early", hs_out, 0);
    chk("up_dta_hold", dt_active, 1);
    step(1);
    chk("up_hs", hs_out, 1);
    chk("up_dta_end", dt_active, 0);
    chk("up_ls", ls_out, 0);

    // commutation, dead_time=3
    dead_time = 8'd3;
    pwm_in = 0;
    step(1);
    chk("c1_hs_fall", hs_out, 0);
    chk("c1_dta", dt_active, 1);
    step(2);
    chk("c1_ls_early", ls_out, 0);
    chk("c1_dta2", dt_active, 1);
    step(1);
    chk("c1_ls", ls_out, 1);
    chk("c1_dta_end", dt_active, 0);
    pwm_in = 1;
    step(1);
    chk("c2_ls_fall", ls_out, 0);
    chk("c2_dta", dt_active, 1);
    step(2);
    chk("c2_hs_early", hs_out, 0);
    step(1);
    chk("c2_hs", hs_out, 1);

    // dead_time 0 and 1 both give one cycle
    dead_time = 8'd0;
    pwm_in = 0;
    step(1);
    chk("d0_hs", hs_out, 0);
    chk("d0_ls", ls_out, 0);
    step(1);
    chk("d0_ls_on", ls_out, 1);
    dead_time = 8'd1;
    pwm_in = 1;
    step(1);
    chk("d1_hs", hs_out, 0);
    chk("d1_ls", ls_out, 0);
    step(1);
    chk("d1_hs_on", hs_out, 1);

    // dead_time change mid-DT keeps current interval
    dead_time = 8'd4;
    pwm_in = 0;
    step(1);
    dead_time = 8'd1;
    step(2);
    chk("mid_ls_a", ls_out, 0);
    step(1);
    chk("mid_ls_b", ls_out, 0);
    step(1);
    chk("mid_ls_on", ls_out, 1);
    pwm_in = 1;
    step(2);
    chk("mid_back_hs", hs_out, 1);

    // narrow pulse swallowed, dead_time=5
    dead_time = 8'd5;
    pwm_in = 0;
    step(2);
    pwm_in = 1;
    step(3);
    chk("np_ls", ls_out, 0);
    chk("np_hs_early", hs_out, 0);
    step(1);
    chk("np_hs", hs_out, 1);
    chk("np_drop", drop_cnt, 1);
    for (int k = 0; k < 299; k++) begin
      pwm_in = 0;
      step(2);
      pwm_in = 1;
      step(4);
    end
    chk("np_sat", drop_cnt, 255);
    chk("np_sat_hs", hs_out, 1);

    // async reset mid-HS_ON
    #3 rst = 1;
    #1;
    chk("arst_hs", hs_out, 0);
    chk("arst_ls", ls_out, 0);
    chk("arst_dta", dt_active, 0);
    chk("arst_drop", drop_cnt, 0);
    step(1);
    rst = 0; pwm_in = 0; dead_time = 8'd2;
    step(2);
    chk("re_ls_early", ls_out, 0);
    step(1);
    chk("re_ls", ls_out, 1);

    // en drop mid-LS_ON, then re-enable
    en = 0;
    step(1);
    chk("en_ls_off", ls_out, 0);
    chk("en_hs_off", hs_out, 0);
    chk("en_dta_off", dt_active, 0);
    en = 1; dead_time = 8'd3;
    step(3);
    chk("en_re_ls_early", ls_out, 0);
    step(1);
    chk("en_re_ls", ls_out, 1);

    // en drop mid-DT
    pwm_in = 1;
    step(1);
    chk("endt_dta", dt_active, 1);
    en = 0;
    step(1);
    chk("endt_off_dta", dt_active, 0);
    chk("endt_off_hs", hs_out, 0);
    step(2);
    en = 1; dead_time = 8'd2;
    step(1);
    chk("endt_re_dta", dt_active, 1);
    step(1);
    chk("endt_re_hs_early", hs_out, 0);
    step(1);
    chk("endt_re_hs", hs_out, 1);

    // random stress
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 7) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 31) == 0)
        dead_time = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) en = ~en;
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
